key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/key_debounce.sv | 136 +++++++++++++
 tb/tb_key_debounce.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for key debouncing: FSM state encoding, default timing
// constants and a counter-width helper.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      DOWN       = 2'd2,
      RELEASE_DB = 2'd3
   } key_state_e;

   // 20 ms debounce window and 1 s long-press threshold at 50 MHz, minus one.
   localparam int unsigned CNT_MAX_DEF  = 999_999;
   localparam int unsigned LONG_MAX_DEF = 49_999_999;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is
// configurable so idle-high and idle-low inputs both start in their rest state.
module sync_2ff #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic din,
   output logic dout
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low mechanical key into a clean level plus one-cycle
// press, release and long-press pulses.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
   parameter int unsigned LONG_MAX = LONG_MAX_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in,
   output logic key_filter,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int unsigned CNT_W  = cnt_width(CNT_MAX);
   localparam int unsigned LONG_W = cnt_width(LONG_MAX);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX);

   logic key_s;

   key_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LONG_W-1:0] long_q, long_d;
   logic              fired_q, fired_d;
   logic              key_filter_q, key_filter_d;
   logic              key_press_q, key_press_d;
   logic              key_release_q, key_release_d;
   logic              key_long_q, key_long_d;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .din       (key_in),
      .dout      (key_s)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      long_d        = long_q;
      fired_d       = fired_q;
      key_filter_d  = key_filter_q;
      key_press_d   = 1'b0;
      key_release_d = 1'b0;
      key_long_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!key_s) begin
               state_d = PRESS_DB;
               cnt_d   = '0;
            end
         end

         PRESS_DB: begin
            if (key_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = DOWN;
               key_filter_d = 1'b0;
               key_press_d  = 1'b1;
               long_d       = '0;
               fired_d      = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Long counter saturates; the fired flag keeps key_long to one pulse
         // per press even across aborted release windows.
         DOWN: begin
            if (key_s) begin
               state_d = RELEASE_DB;
               cnt_d   = '0;
            end else if (long_q != LONG_LAST) begin
               long_d = long_q + LONG_W'(1);
            end else if (!fired_q) begin
               key_long_d = 1'b1;
               fired_d    = 1'b1;
            end
         end

         RELEASE_DB: begin
            if (!key_s) begin
               state_d = DOWN;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = IDLE;
               key_filter_d  = 1'b1;
               key_release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         long_q        <= '0;
         fired_q       <= 1'b0;
         key_filter_q  <= 1'b1;
         key_press_q   <= 1'b0;
         key_release_q <= 1'b0;
         key_long_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         long_q        <= long_d;
         fired_q       <= fired_d;
         key_filter_q  <= key_filter_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
         key_long_q    <= key_long_d;
      end
   end

   assign key_filter  = key_filter_q;
   assign key_press   = key_press_q;
   assign key_release = key_release_q;
   assign key_long    = key_long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a short debounce window (CNT_MAX=9)
// and long-press threshold (LONG_MAX=49).
module tb_key_debounce;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   logic key_in;
   logic key_filter;
   logic key_press;
   logic key_release;
   logic key_long;

   int checks   = 0;
   int failures = 0;
   int press_n  = 0;
   int rel_n    = 0;
   int long_n   = 0;
   int excl_n   = 0;
   int p0, r0, l0;

   key_debounce #(
      .CNT_MAX  (9),
      .LONG_MAX (49)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_in),
      .key_filter  (key_filter),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   always #5 sys_clk = ~sys_clk;

   // Pulses are one cycle wide, so each is seen by exactly one falling edge.
   always @(negedge sys_clk) begin
      if (key_press)   press_n <= press_n + 1;
      if (key_release) rel_n   <= rel_n + 1;
      if (key_long)    long_n  <= long_n + 1;
      if (int'(key_press) + int'(key_release) + int'(key_long) > 1)
         excl_n <= excl_n + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic snap();
      p0 = press_n;
      r0 = rel_n;
      l0 = long_n;
   endtask

   initial begin
      key_in    = 1'b1;
      sys_rst_n = 1'b0;
      tick(3);
      chk("rst_filter",  int'(key_filter),  1);
      chk("rst_press",   int'(key_press),   0);
      chk("rst_release", int'(key_release), 0);
      chk("rst_long",    int'(key_long),    0);
      sys_rst_n = 1'b1;
      tick(5);

      // Clean press held 200 cycles, then clean release
      snap();
      key_in = 1'b0;
      tick(12);
      chk("press_e12_filter", int'(key_filter), 1);
      chk("press_e12_pulse",  int'(key_press),  0);
      tick();
      chk("press_e13_filter", int'(key_filter), 0);
      chk("press_e13_pulse",  int'(key_press),  1);
      tick();
      chk("press_e14_pulse",  int'(key_press),  0);
      chk("press_e14_filter", int'(key_filter), 0);
      tick(48);
      chk("long_e62", int'(key_long), 0);
      tick();
      chk("long_e63", int'(key_long), 1);
      tick();
      chk("long_e64", int'(key_long), 0);
      tick(136);
      chk("long_count",  long_n - l0,  1);
      chk("press_count", press_n - p0, 1);
      key_in = 1'b1;
      tick(12);
      chk("rel_e12_filter", int'(key_filter),  0);
      chk("rel_e12_pulse",  int'(key_release), 0);
      tick();
      chk("rel_e13_filter", int'(key_filter),  1);
      chk("rel_e13_pulse",  int'(key_release), 1);
      tick();
      chk("rel_e14_pulse",  int'(key_release), 0);
      chk("rel_count",      rel_n - r0,        1);

      // Short glitch: 5 cycles low
      tick(10);
      snap();
      key_in = 1'b0;
      tick(5);
      key_in = 1'b1;
      tick(30);
      chk("glitch_filter",  int'(key_filter), 1);
      chk("glitch_press",   press_n - p0,     0);
      chk("glitch_release", rel_n - r0,       0);

      // Bounce every 3 cycles for 30 cycles, then settle low
      snap();
      for (int i = 0; i < 10; i++) begin
         key_in = (i % 2 == 1) ? 1'b1 : 1'b0;
         tick(3);
      end
      key_in = 1'b0;
      tick(12);
      chk("bounce_e12_filter", int'(key_filter), 1);
      chk("bounce_e12_count",  press_n - p0,     0);
      tick();
      chk("bounce_e13_pulse",  int'(key_press),  1);
      tick();
      chk("bounce_press_count", press_n - p0, 1);

      // Release bounce after long press has fired
      tick(60);
      chk("bounce_long_count", long_n - l0, 1);
      snap();
      key_in = 1'b1;
      tick(5);
      key_in = 1'b0;
      tick(2);
      key_in = 1'b1;
      tick(2);
      chk("relb_state_down", int'(dut.state_q), int'(key_pkg::DOWN));
      tick(10);
      chk("relb_e12_filter", int'(key_filter),  0);
      chk("relb_e12_pulse",  int'(key_release), 0);
      tick();
      chk("relb_e13_pulse",  int'(key_release), 1);
      chk("relb_e13_filter", int'(key_filter),  1);
      tick();
      chk("relb_rel_count",  rel_n - r0,  1);
      chk("relb_long_count", long_n - l0, 0);

      // Reset while held down
      tick(5);
      snap();
      key_in = 1'b0;
      tick(20);
      chk("mid_filter", int'(key_filter), 0);
      sys_rst_n = 1'b0;
      #2;
      chk("mid_rst_filter",  int'(key_filter),  1);
      chk("mid_rst_press",   int'(key_press),   0);
      chk("mid_rst_release", int'(key_release), 0);
      chk("mid_rst_long",    int'(key_long),    0);
      tick(2);
      sys_rst_n = 1'b1;
      tick(12);
      chk("mid_e12_filter", int'(key_filter), 1);
      chk("mid_e12_press",  int'(key_press),  0);
      tick();
      chk("mid_e13_press",  int'(key_press),  1);
      chk("mid_e13_filter", int'(key_filter), 0);
      tick();
      chk("mid_rel_count",   rel_n - r0,   0);
      chk("mid_press_count", press_n - p0, 2);

      chk("pulse_exclusive", excl_n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
